uart_tx_scheduler: RTL and testbench

Parametrised successor to the UART controller's TX pipeline. Arbitrates NUM_CH message sources round-robin onto the single TX bridge message interface. Injects STALL/UNSTALL control frames with priority over data whenever the RX path's backpressure state changes. Tags each data frame's header with its source channel ID; this generalises the fixed two-way encrypted/decrypted mux to N channels with a per-channel enable mask.

---
 rtl/uart_tx_scheduler.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler of NUM_CH message sources onto one TX bridge, with STALL/UNSTALL control-frame injection.
// Optional UART_SCHED_FRAME_CNT_EN adds a saturating count of completed data frames on frames_sent_out.
module uart_tx_scheduler #(
    parameter int                     NUM_CH         = 3,
    parameter int                     MESSAGE_SIZE   = 512,
    parameter int                     HEADER_SIZE    = 32,
    parameter int                     CH_ID_LSB      = 16,
    parameter logic [HEADER_SIZE-1:0] STALL_HEADER   = 32'h0000_0080,
    parameter logic [HEADER_SIZE-1:0] UNSTALL_HEADER = 32'h0000_0040
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [NUM_CH-1:0]              ch_valid_in,
    output logic [NUM_CH-1:0]              ch_ready_out,
    input  logic [NUM_CH-1:0]              ch_enable_in,
    input  logic [NUM_CH*MESSAGE_SIZE-1:0] ch_message_in,
    input  logic [NUM_CH*HEADER_SIZE-1:0]  ch_header_in,
    input  logic                           rx_stalled_in,
    output logic                           bdge_valid_out,
    input  logic                           bdge_ready_in,
    output logic [MESSAGE_SIZE-1:0]        bdge_message_out,
    output logic [HEADER_SIZE-1:0]         bdge_header_out,
    output logic                           bdge_is_signal_out,
`ifdef UART_SCHED_FRAME_CNT_EN
    output logic                           busy_out,
    output logic [15:0]                    frames_sent_out
`else
    output logic                           busy_out
`endif
);
    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, SEND_CTRL, SEND_DATA} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CH_W-1:0]         r_rr_ptr;
    logic                    r_stall_sent;
    logic                    r_ctrl_stall;
    logic                    r_valid;
    logic                    r_is_signal;
    logic [MESSAGE_SIZE-1:0] r_message;
    logic [HEADER_SIZE-1:0]  r_header;

    logic [NUM_CH-1:0]       w_req;
    logic                    w_grant_vld;
    logic [CH_W-1:0]         w_grant_idx;
    logic [CH_W-1:0]         w_cand;
    logic [CH_W-1:0]         w_rr_nxt;
    logic [NUM_CH-1:0]       w_ready;
    logic                    w_stall_pend;
    logic                    w_unstall_pend;
    logic                    w_ctrl_pend;
    logic                    w_load_ctrl;
    logic                    w_load_data;
    logic                    w_done;
    logic [HEADER_SIZE-1:0]  w_hdr;

    assign w_req          = ch_valid_in & ch_enable_in;
    assign w_stall_pend   = rx_stalled_in & ~r_stall_sent;
    assign w_unstall_pend = ~rx_stalled_in & r_stall_sent;
    assign w_ctrl_pend    = w_stall_pend | w_unstall_pend;

    // Scan offsets from the far end down so the closest eligible channel to rr_ptr wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            int pos;
            pos = int'(r_rr_ptr) + k;
            if (pos >= NUM_CH) pos = pos - NUM_CH;
            w_cand = CH_W'(pos);
            if (w_req[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    assign w_rr_nxt = (w_grant_idx == CH_W'(NUM_CH - 1)) ? '0 : w_grant_idx + 1'b1;

    always_comb begin
        w_hdr = ch_header_in[int'(w_grant_idx)*HEADER_SIZE +: HEADER_SIZE];
        w_hdr[CH_ID_LSB +: CH_W] = w_grant_idx;
    end

    always_comb begin
        w_ready = '0;
        if (r_state == IDLE && !w_ctrl_pend && w_grant_vld)
            w_ready[w_grant_idx] = 1'b1;
    end

    assign ch_ready_out = w_ready;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_ctrl = 1'b0;
        w_load_data = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ctrl_pend) begin
                    w_load_ctrl = 1'b1;
                    w_state_nxt = SEND_CTRL;
                end else if (w_grant_vld) begin
                    w_load_data = 1'b1;
                    w_state_nxt = SEND_DATA;
                end
            end
            SEND_CTRL, SEND_DATA: begin
                if (r_valid && bdge_ready_in) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Frame registers only move on the IDLE exit edge and the completing handshake.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_valid      <= 1'b0;
            r_is_signal  <= 1'b0;
            r_message    <= '0;
            r_header     <= '0;
            r_rr_ptr     <= '0;
            r_stall_sent <= 1'b0;
            r_ctrl_stall <= 1'b0;
        end else if (w_load_ctrl) begin
            r_valid      <= 1'b1;
            r_is_signal  <= 1'b1;
            r_message    <= '0;
            r_header     <= w_stall_pend ? STALL_HEADER : UNSTALL_HEADER;
            r_ctrl_stall <= w_stall_pend;
        end else if (w_load_data) begin
            r_valid     <= 1'b1;
            r_is_signal <= 1'b0;
            r_message   <= ch_message_in[int'(w_grant_idx)*MESSAGE_SIZE +: MESSAGE_SIZE];
            r_header    <= w_hdr;
            r_rr_ptr    <= w_rr_nxt;
        end else if (w_done) begin
            r_valid <= 1'b0;
            if (r_state == SEND_CTRL) r_stall_sent <= r_ctrl_stall;
        end
    end

`ifdef UART_SCHED_FRAME_CNT_EN
    logic [15:0] r_frames;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            r_frames <= '0;
        else if (r_state == SEND_DATA && r_valid && bdge_ready_in && r_frames != 16'hFFFF)
            r_frames <= r_frames + 16'd1;
    end

    assign frames_sent_out = r_frames;
`endif

    assign bdge_valid_out     = r_valid;
    assign bdge_is_signal_out = r_is_signal;
    assign bdge_message_out   = r_message;
    assign bdge_header_out    = r_header;
    assign busy_out           = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomised bench for uart_tx_scheduler against a frame-level reference model.
module tb_uart_tx_scheduler;
    localparam int N   = 3;
    localparam int MS  = 512;
    localparam int HS  = 32;
    localparam int LSB = 16;
    localparam int CW  = $clog2(N);
    localparam logic [HS-1:0] STALL_H   = 32'h0000_0080;
    localparam logic [HS-1:0] UNSTALL_H = 32'h0000_0040;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b1;
    logic [N-1:0]    ch_valid_in = '0;
    logic [N-1:0]    ch_ready_out;
    logic [N-1:0]    ch_enable_in = '1;
    logic [N*MS-1:0] ch_message_in;
    logic [N*HS-1:0] ch_header_in;
    logic            rx_stalled_in = 1'b0;
    logic            bdge_valid_out;
    logic            bdge_ready_in = 1'b0;
    logic [MS-1:0]   bdge_message_out;
    logic [HS-1:0]   bdge_header_out;
    logic            bdge_is_signal_out;
    logic            busy_out;
`ifdef UART_SCHED_FRAME_CNT_EN
    logic [15:0]     frames_sent_out;
`endif

    logic [MS-1:0] ch_msg [N];
    logic [HS-1:0] ch_hdr [N];

    always #5 clk_in = ~clk_in;

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign ch_message_in[i*MS +: MS] = ch_msg[i];
        assign ch_header_in[i*HS +: HS]  = ch_hdr[i];
    end

    uart_tx_scheduler dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .ch_valid_in        (ch_valid_in),
        .ch_ready_out       (ch_ready_out),
        .ch_enable_in       (ch_enable_in),
        .ch_message_in      (ch_message_in),
        .ch_header_in       (ch_header_in),
        .rx_stalled_in      (rx_stalled_in),
        .bdge_valid_out     (bdge_valid_out),
        .bdge_ready_in      (bdge_ready_in),
        .bdge_message_out   (bdge_message_out),
        .bdge_header_out    (bdge_header_out),
        .bdge_is_signal_out (bdge_is_signal_out),
`ifdef UART_SCHED_FRAME_CNT_EN
        .busy_out           (busy_out),
        .frames_sent_out    (frames_sent_out)
`else
        .busy_out           (busy_out)
`endif
    );

    // Reference model: one frame slot plus the stall bookkeeping and fairness pointer.
    bit            m_busy;
    bit            m_sig;
    bit            m_is_stall;
    bit            m_stall_sent;
    int            m_rr;
    int unsigned   m_cnt;
    logic [MS-1:0] m_msg;
    logic [HS-1:0] m_hdr;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [MS-1:0] obs, input logic [MS-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [MS-1:0] rand_msg();
        logic [MS-1:0] r;
        for (int i = 0; i < MS/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_sig = 0; m_is_stall = 0; m_stall_sent = 0;
        m_rr = 0; m_cnt = 0; m_msg = '0; m_hdr = '0;
    endtask

    function automatic int pick(input logic [N-1:0] v, input logic [N-1:0] en);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (v[c] && en[c]) return c;
        end
        return -1;
    endfunction

    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] en,
                         input logic rx, input logic br, input bit rnd_data);
        bit           ctrl;
        int           g;
        logic [N-1:0] exp_rdy;
        logic [HS-1:0] h;
        @(negedge clk_in);
        ch_valid_in   = v;
        ch_enable_in  = en;
        rx_stalled_in = rx;
        bdge_ready_in = br;
        if (rnd_data)
            for (int i = 0; i < N; i++) begin
                ch_msg[i] = rand_msg();
                ch_hdr[i] = $urandom;
            end
        #1;
        ctrl = rx ? !m_stall_sent : m_stall_sent;
        g = pick(v, en);
        exp_rdy = '0;
        if (!m_busy && !ctrl && g >= 0) exp_rdy[g] = 1'b1;
        chk("ready", ch_ready_out, exp_rdy);
        chk("valid", bdge_valid_out, m_busy);
        chk("busy", busy_out, m_busy);
        chk("msg", bdge_message_out, m_msg);
        chk("hdr", bdge_header_out, m_hdr);
        chk("is_signal", bdge_is_signal_out, m_sig);
`ifdef UART_SCHED_FRAME_CNT_EN
        chk("frames", frames_sent_out, m_cnt);
`endif
        if (!m_busy) begin
            if (ctrl) begin
                m_busy = 1; m_sig = 1; m_is_stall = rx;
                m_msg = '0; m_hdr = rx ? STALL_H : UNSTALL_H;
            end else if (g >= 0) begin
                h = ch_hdr[g];
                h[LSB +: CW] = CW'(g);
                m_busy = 1; m_sig = 0; m_msg = ch_msg[g]; m_hdr = h;
                m_rr = (g + 1) % N;
            end
        end else if (br) begin
            m_busy = 0;
            if (m_sig) m_stall_sent = m_is_stall;
            else if (m_cnt < 16'hFFFF) m_cnt++;
        end
    endtask

    logic          rx_r;
    logic [N-1:0]  en_r;

    initial begin
        for (int i = 0; i < N; i++) begin
            ch_msg[i] = '0;
            ch_hdr[i] = '0;
        end
        model_reset();
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_valid", bdge_valid_out, 1'b0);
        chk("rst_busy", busy_out, 1'b0);
        chk("rst_ready", ch_ready_out, '0);
        chk("rst_hdr", bdge_header_out, '0);
        chk("rst_msg", bdge_message_out, '0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Single accept from channel 0.
        ch_msg[0] = 512'hA5;
        ch_hdr[0] = 32'h0;
        cycle(3'b001, 3'b111, 1'b0, 1'b1, 1'b0);
        cycle(3'b000, 3'b111, 1'b0, 1'b1, 1'b0);
        chk("t1_msg", bdge_message_out, 512'hA5);
        chk("t1_id", bdge_header_out[17:16], 2'd0);

        // Round robin with all channels busy.
        repeat (13) cycle(3'b111, 3'b111, 1'b0, 1'b1, 1'b1);

        // Stall then unstall with data pending.
        repeat (4) cycle(3'b010, 3'b111, 1'b1, 1'b1, 1'b1);
        repeat (4) cycle(3'b010, 3'b111, 1'b0, 1'b1, 1'b1);

        // Bridge backpressure for 20 cycles.
        cycle(3'b111, 3'b111, 1'b0, 1'b0, 1'b1);
        repeat (20) cycle(3'b111, 3'b111, 1'b0, 1'b0, 1'b1);
        repeat (3) cycle(3'b111, 3'b111, 1'b0, 1'b1, 1'b1);

        // Channel 1 masked off.
        repeat (10) cycle(3'b111, 3'b101, 1'b0, 1'b1, 1'b1);

        // All enables low: only control frames may move.
        repeat (3) cycle(3'b111, 3'b000, 1'b1, 1'b1, 1'b1);
        repeat (3) cycle(3'b111, 3'b000, 1'b0, 1'b1, 1'b1);

        // Randomised traffic.
        rx_r = 1'b0;
        repeat (1500) begin
            if ($urandom_range(7) == 0) rx_r = ~rx_r;
            en_r = ($urandom_range(3) == 0) ? N'($urandom) : '1;
            cycle(N'($urandom), en_r, rx_r, ($urandom_range(3) != 0), 1'b1);
        end

        // Asynchronous reset with a frame in flight.
        repeat (2) cycle(3'b111, 3'b111, rx_r, 1'b0, 1'b1);
        chk("arst_pre_busy", busy_out, 1'b1);
        @(posedge clk_in);
        #3;
        rst_in = 1'b1;
        #1;
        chk("arst_valid", bdge_valid_out, 1'b0);
        chk("arst_busy", busy_out, 1'b0);
        chk("arst_hdr", bdge_header_out, '0);
`ifdef UART_SCHED_FRAME_CNT_EN
        chk("arst_frames", frames_sent_out, 16'd0);
`endif
        ch_valid_in   = '0;
        rx_stalled_in = 1'b0;
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        cycle(3'b111, 3'b111, 1'b0, 1'b1, 1'b1);
        chk("arst_first_grant", ch_ready_out, 3'b001);
        repeat (4) cycle(3'b111, 3'b111, 1'b0, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
